dac_segment_encoder: RTL and testbench

// Digital front end of the segmented current-steering DAC. Converts an unsigned code into the
// 7 binary LSB controls and 17 thermometer unit-cell controls, each with its complement, plus pdb.

---
 rtl/dac_pkg.sv | 32 +++
 rtl/dwa_rotator.sv | 38 +++
 rtl/dac_segment_encoder.sv | 166 ++++++++++++++++
 tb/tb_dac_segment_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, state type and code saturation helper for the segmented DAC encoder.
// No ports: imported by dac_segment_encoder and dwa_rotator.
package dac_pkg;

    localparam int N_BIN     = 7;
    localparam int N_THERM   = 17;
    localparam int CODE_W    = 12;
    localparam int CODE_MAX  = N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1;
    localparam int PU_CYCLES = 16;
    localparam int PD_CYCLES = 4;
    localparam int PTR_W     = $clog2(N_THERM);
    localparam int NU_W      = $clog2(N_THERM + 1);
    localparam int CNT_W     = $clog2(PU_CYCLES);

    typedef enum logic [1:0] {
        OFF,
        WAKE,
        RUN,
        DRAIN
    } dac_enc_state_t;

    // Returns {clipped, code}; codes above full scale clip to CODE_MAX.
    function automatic logic [CODE_W:0] sat_code(input logic [CODE_W-1:0] c);
        logic [CODE_W-1:0] lim;
        lim = CODE_W'(CODE_MAX);
        if (c > lim) begin
            return {1'b1, lim};
        end
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/dwa_rotator.sv
// Unit-cell selector: n active units placed from ptr (DWA) or from unit 0, plus next pointer.
// Ports: n_i, ptr_i, dem_en_i in; mask_o (N_THERM), ptr_next_o out. Purely combinational.
module dwa_rotator
    import dac_pkg::*;
(
    input  logic [NU_W-1:0]    n_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               dem_en_i,
    output logic [N_THERM-1:0] mask_o,
    output logic [PTR_W-1:0]   ptr_next_o
);

    logic [N_THERM-1:0]   base;
    logic [2*N_THERM-1:0] wide;
    logic [PTR_W:0]       sum;

    always_comb begin
        base = '0;
        for (int k = 0; k < N_THERM; k++) begin
            base[k] = (NU_W'(k) < n_i);
        end
        // Rotate left by ptr: bits pushed past the top fold back to unit 0.
        wide = {{N_THERM{1'b0}}, base} << ptr_i;
        sum  = (PTR_W + 1)'(ptr_i) + (PTR_W + 1)'(n_i);
        if (dem_en_i) begin
            mask_o = wide[N_THERM-1:0] | wide[2*N_THERM-1:N_THERM];
            if (sum >= (PTR_W + 1)'(N_THERM)) begin
                ptr_next_o = PTR_W'(sum - (PTR_W + 1)'(N_THERM));
            end else begin
                ptr_next_o = PTR_W'(sum);
            end
        end else begin
            mask_o     = base;
            ptr_next_o = ptr_i;
        end
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// Segmented DAC front end: power sequencing FSM, 2-stage code pipeline, DWA, complements.
// Ports: clk, rstb, enable, dem_en, code, code_valid in; ready, pdb, datain(b), datatherm(b), sat_flag out.
module dac_segment_encoder
    import dac_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               enable,
    input  logic               dem_en,
    input  logic [CODE_W-1:0]  code,
    input  logic               code_valid,
    output logic               ready,
    output logic               pdb,
    output logic [N_BIN-1:0]   datain,
    output logic [N_BIN-1:0]   datainb,
    output logic [N_THERM-1:0] datatherm,
    output logic [N_THERM-1:0] datathermb,
    output logic               sat_flag
);

    dac_enc_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CODE_W-1:0]  s1_code_q;
    logic               s1_sat_q;
    logic [CODE_W:0]    sat_w;

    logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_next;
    logic               dem_q;
    logic [NU_W-1:0]    n_s2;
    logic [N_BIN-1:0]   lsb_s2;
    logic [N_THERM-1:0] mask_s2;
    logic               live;

    logic               pdb_q, pdb_d;
    logic               sat_q, sat_d;
    logic [N_BIN-1:0]   in_q, in_d, inb_q, inb_d;
    logic [N_THERM-1:0] th_q, th_d, thb_q, thb_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (enable) begin
                    state_d = WAKE;
                    cnt_d   = '0;
                end
            end
            WAKE: begin
                if (!enable) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(PU_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(PD_CYCLES - 1)) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready  = (state_q == RUN);
    assign sat_w  = sat_code(code);
    assign n_s2   = NU_W'(s1_code_q >> N_BIN);
    assign lsb_s2 = s1_code_q[N_BIN-1:0];

    // The output word follows the state being entered, so the drain
    // zero words and the all-zero OFF bus line up with pdb.
    assign live = (state_d == RUN);

    dwa_rotator u_dwa (
        .n_i        (n_s2),
        .ptr_i      (ptr_q),
        .dem_en_i   (dem_en),
        .mask_o     (mask_s2),
        .ptr_next_o (ptr_next)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (dem_en != dem_q) begin
            ptr_d = '0;
        end else if (live && dem_en) begin
            ptr_d = ptr_next;
        end
    end

    always_comb begin
        in_d  = '0;
        inb_d = '0;
        th_d  = '0;
        thb_d = '0;
        sat_d = 1'b0;
        pdb_d = (state_d != OFF);
        if (live) begin
            in_d  = lsb_s2;
            inb_d = ~lsb_s2;
            th_d  = mask_s2;
            thb_d = ~mask_s2;
            sat_d = s1_sat_q;
        end else if (state_d != OFF) begin
            inb_d = '1;
            thb_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            s1_code_q <= '0;
            s1_sat_q  <= 1'b0;
            ptr_q     <= '0;
            dem_q     <= 1'b0;
            pdb_q     <= 1'b0;
            sat_q     <= 1'b0;
            in_q      <= '0;
            inb_q     <= '0;
            th_q      <= '0;
            thb_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ready && code_valid) begin
                s1_sat_q  <= sat_w[CODE_W];
                s1_code_q <= sat_w[CODE_W-1:0];
            end
            ptr_q <= ptr_d;
            dem_q <= dem_en;
            pdb_q <= pdb_d;
            sat_q <= sat_d;
            in_q  <= in_d;
            inb_q <= inb_d;
            th_q  <= th_d;
            thb_q <= thb_d;
        end
    end

    assign pdb        = pdb_q;
    assign sat_flag   = sat_q;
    assign datain     = in_q;
    assign datainb    = inb_q;
    assign datatherm  = th_q;
    assign datathermb = thb_q;

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Directed + randomized bench for dac_segment_encoder against a cycle-level behavioural model.
// No ports: drives the DUT, prints FAIL lines on mismatch and one summary line.
module tb_dac_segment_encoder;

    localparam int UNITS = 17;
    localparam int LSBW  = 128;
    localparam int FULL  = 2303;
    localparam int P_OFF = 0, P_WAKE = 1, P_RUN = 2, P_DRAIN = 3;

    logic        clk;
    logic        rstb;
    logic        enable;
    logic        dem_en;
    logic [11:0] code;
    logic        code_valid;
    logic        ready;
    logic        pdb;
    logic [6:0]  datain;
    logic [6:0]  datainb;
    logic [16:0] datatherm;
    logic [16:0] datathermb;
    logic        sat_flag;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int          m_ph, m_left, m_code, m_ptr;
    logic        m_sat, m_dem;
    logic        e_ready, e_pdb, e_sat;
    logic [6:0]  e_in, e_inb;
    logic [16:0] e_th, e_thb;

    dac_segment_encoder dut (
        .clk        (clk),
        .rstb       (rstb),
        .enable     (enable),
        .dem_en     (dem_en),
        .code       (code),
        .code_valid (code_valid),
        .ready      (ready),
        .pdb        (pdb),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dut_word();
        return {13'd0, ready, pdb, datain, datainb,
                datatherm, datathermb, sat_flag};
    endfunction

    function automatic logic [63:0] exp_word();
        return {13'd0, e_ready, e_pdb, e_in, e_inb,
                e_th, e_thb, e_sat};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ph = P_OFF; m_left = 0; m_code = 0; m_ptr = 0;
        m_sat = 1'b0; m_dem = 1'b0;
        e_ready = 1'b0; e_pdb = 1'b0; e_sat = 1'b0;
        e_in = '0; e_inb = '0; e_th = '0; e_thb = '0;
    endtask

    // One clock of the model, from the inputs present before the edge.
    task automatic m_step();
        int          np, n;
        logic [16:0] msk;
        np = m_ph;
        case (m_ph)
            P_OFF: if (enable) begin np = P_WAKE; m_left = 16; end
            P_WAKE: begin
                if (!enable) begin
                    np = P_DRAIN; m_left = 4;
                end else begin
                    m_left--;
                    if (m_left == 0) np = P_RUN;
                end
            end
            P_RUN: if (!enable) begin np = P_DRAIN; m_left = 4; end
            default: begin
                m_left--;
                if (m_left == 0) np = P_OFF;
            end
        endcase
        e_in = '0; e_inb = '0; e_th = '0; e_thb = '0; e_sat = 1'b0;
        if (np == P_RUN) begin
            n   = m_code / LSBW;
            msk = '0;
            for (int i = 0; i < n; i++) begin
                if (dem_en) msk[(m_ptr + i) % UNITS] = 1'b1;
                else msk[i] = 1'b1;
            end
            e_in  = 7'(m_code % LSBW);
            e_inb = ~e_in;
            e_th  = msk;
            e_thb = ~msk;
            e_sat = m_sat;
            if (dem_en != m_dem) m_ptr = 0;
            else if (dem_en) m_ptr = (m_ptr + n) % UNITS;
        end else begin
            if (np != P_OFF) begin
                e_inb = '1;
                e_thb = '1;
            end
            if (dem_en != m_dem) m_ptr = 0;
        end
        m_dem = dem_en;
        if (m_ph == P_RUN && code_valid) begin
            m_sat  = (int'(code) > FULL);
            m_code = m_sat ? FULL : int'(code);
        end
        m_ph    = np;
        e_ready = (np == P_RUN);
        e_pdb   = (np != P_OFF);
    endtask

    task automatic cycle(input string tag);
        m_step();
        @(posedge clk);
        #1;
        chk(tag, dut_word(), exp_word());
    endtask

    initial begin
        rstb = 1'b0; enable = 1'b1; dem_en = 1'b0;
        code = '0; code_valid = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_word(), 64'd0);
        rstb = 1'b1;

        // power-up: 16 forced-zero WAKE words, then ready
        for (int i = 0; i < 16; i++) begin
            cycle("wake");
            chk("wake_pdb_rdy", 64'({pdb, ready}), 64'(2'b10));
            chk("wake_inb", 64'(datainb), 64'(7'h7F));
            chk("wake_thb", 64'(datathermb), 64'(17'h1FFFF));
        end
        cycle("run_entry");
        chk("ready_up", 64'(ready), 64'd1);

        // binary/thermometer split with 2-cycle latency
        code = 12'd300; code_valid = 1'b1;
        cycle("c300_a");
        code_valid = 1'b0;
        cycle("c300_b");
        chk("c300_therm", 64'(datatherm), 64'(17'h00003));
        chk("c300_in", 64'(datain), 64'(7'd44));
        chk("c300_inb", 64'(datainb), 64'(7'h53));
        chk("c300_thb", 64'(datathermb), 64'(17'h1FFFC));

        // saturation flag tied to the clipped word only
        code = 12'd4095; code_valid = 1'b1;
        cycle("sat_a");
        code = 12'd2303;
        cycle("sat_b");
        chk("sat_word", 64'({sat_flag, datain, datatherm}),
            64'({1'b1, 7'h7F, 17'h1FFFF}));
        code_valid = 1'b0;
        cycle("sat_c");
        chk("full_word", 64'({sat_flag, datain, datatherm}),
            64'({1'b0, 7'h7F, 17'h1FFFF}));

        // DWA rotation 0 -> 5 -> 10 -> 3
        dem_en = 1'b1;
        cycle("dem_on_a");
        cycle("dem_on_b");
        code = 12'd640; code_valid = 1'b1;
        cycle("dwa_a");
        cycle("dwa_b");
        chk("dwa_mask0", 64'(datatherm), 64'(17'h0001F));
        code = 12'd1280;
        cycle("dwa_c");
        chk("dwa_mask1", 64'(datatherm), 64'(17'h003E0));
        code_valid = 1'b0;
        cycle("dwa_d");
        chk("dwa_wrap", 64'(datatherm), 64'(17'h1FC07));
        cycle("dwa_e");
        chk("dwa_ptr3", 64'(datatherm), 64'(17'h01FF8));

        // random run, enable held
        for (int i = 0; i < 300; i++) begin
            code       = 12'($urandom_range(0, 4095));
            code_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) dem_en = ~dem_en;
            cycle("rand_run");
        end

        // drain: ready drops, 4 zero words, then OFF
        enable = 1'b0;
        cycle("drain_1");
        chk("drain_rdy", 64'({ready, pdb}), 64'(2'b01));
        chk("drain_thb", 64'(datathermb), 64'(17'h1FFFF));
        for (int i = 0; i < 3; i++) cycle("drain_n");
        chk("drain_pdb", 64'(pdb), 64'd1);
        cycle("off");
        chk("off_bus", 64'({pdb, datainb, datathermb}), 64'd0);
        repeat (2) cycle("off_idle");
        enable = 1'b1;
        for (int i = 0; i < 17; i++) cycle("rewake");
        chk("rewake_rdy", 64'(ready), 64'd1);

        // enable back high mid-drain: drain completes, OFF once, rewake
        enable = 1'b0;
        cycle("gl_drain");
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle("gl_drain_n");
        cycle("gl_off");
        chk("gl_off_pdb", 64'(pdb), 64'd0);
        cycle("gl_wake");
        chk("gl_wake", 64'({pdb, ready}), 64'(2'b10));

        // random enable/dem_en/code mix
        for (int i = 0; i < 400; i++) begin
            code       = 12'($urandom_range(0, 4095));
            code_valid = ($urandom_range(0, 3) != 0);
            enable     = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 19) == 0) dem_en = ~dem_en;
            cycle("rand_mix");
        end

        // async reset mid-RUN
        enable = 1'b1; dem_en = 1'b1; code_valid = 1'b1;
        for (int i = 0; i < 40 && !e_ready; i++) cycle("to_run");
        chk("reach_run", 64'(ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            code = 12'($urandom_range(128, 2303));
            cycle("pre_rst");
        end
        #2;
        rstb = 1'b0;
        #1;
        chk("async_rst", dut_word(), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        rstb = 1'b1;
        code_valid = 1'b0;
        for (int i = 0; i < 17; i++) cycle("post_rst");
        chk("post_rst_rdy", 64'(ready), 64'd1);
        code = 12'd640; code_valid = 1'b1;
        cycle("ptr0_a");
        code_valid = 1'b0;
        cycle("ptr0_b");
        chk("ptr0_mask", 64'(datatherm), 64'(17'h0001F));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
